// File: rtl/mux8way_rr_collector.sv
// Eight-channel round-robin collector feeding a one-entry registered output buffer.
// Every buffered word carries the 3-bit index of the channel it came from.
`default_nettype none

module mux8way_rr_collector #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic [2:0]       ptr;
  logic             free;
  logic             grant_found;
  logic [2:0]       grant_idx;
  logic [2:0]       cand;
  logic             transfer;
  logic [WIDTH-1:0] words [8];

  assign free = !out_valid || out_ready;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      words[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The search starts at ptr and wraps, so the most recent winner is tried last.
  // Only in_valid and ptr are inspected, which keeps in_ready independent of in_data.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + k[2:0];
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // rst_n gates the grant directly because a cleared buffer looks free.
  assign transfer = rst_n && free && grant_found;

  always_comb begin
    in_ready = 8'h00;
    if (transfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      ptr       <= 3'd0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= words[grant_idx];
      out_sel   <= grant_idx;
      ptr       <= grant_idx + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux8way_rr_collector.sv
// Self-checking bench for mux8way_rr_collector: directed scenarios plus random traffic
// compared against a cycle-level reference model of the arbitration rules.
`default_nettype none

module tb_mux8way_rr_collector;
  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         in_valid = 8'h00;
  logic [8*WIDTH-1:0] in_data = '0;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;
  int               last_grant;

  mux8way_rr_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid    = 1'b0;
    m_data     = '0;
    m_sel      = 0;
    m_ptr      = 0;
    last_grant = -1;
  endtask

  task automatic set_word(input int ch, input logic [WIDTH-1:0] w);
    in_data[ch*WIDTH +: WIDTH] = w;
  endtask

  task automatic do_reset();
    in_valid  = 8'h00;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic step(input string tag);
    int g;
    logic free;
    logic [7:0] er;
    free = !m_valid || out_ready;
    g = -1;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (m_ptr + k) % 8;
      if (g < 0 && in_valid[c]) g = c;
    end
    er = (free && g >= 0) ? 8'(1 << g) : 8'h00;
    #2;
    n_checks++;
    if (in_ready !== er) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, er);
    end
    @(posedge clk);
    if (free && g >= 0) begin
      m_valid    = 1'b1;
      m_data     = in_data[g*WIDTH +: WIDTH];
      m_sel      = g;
      m_ptr      = (g + 1) % 8;
      last_grant = g;
    end else begin
      if (out_ready) m_valid = 1'b0;
      last_grant = -1;
    end
    #1;
    n_checks++;
    if (out_valid !== m_valid || out_data !== m_data || out_sel !== 3'(m_sel)) begin
      n_fail++;
      $display("FAIL %s output: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
               tag, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 8'hFF;
    #3;
    n_checks++;
    if (in_ready !== 8'h00 || out_valid !== 1'b0 || out_data !== '0 || out_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got r=%b v=%b d=%h s=%0d expected all zero",
               in_ready, out_valid, out_data, out_sel);
    end
    do_reset();
    for (int i = 0; i < 5; i++) step("reset_idle");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 8'b0000_1000;
    set_word(3, 16'h00C3);
    step("single");
    in_valid = 8'h00;
    n_checks++;
    if (out_data !== 16'h00C3 || out_sel !== 3'd3 || m_ptr != 4) begin
      n_fail++;
      $display("FAIL single_word: got d=%h s=%0d ptr=%0d expected d=00c3 s=3 ptr=4",
               out_data, out_sel, m_ptr);
    end
    step("single_drain");
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_word(i, 16'h0010 + 16'(i));
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step("wrap");
      n_checks++;
      if (out_sel !== 3'(i % 8) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_seq: got s=%0d v=%b expected s=%0d v=1", out_sel, out_valid, i % 8);
      end
    end
    in_valid = 8'h00;
    step("wrap_drain");
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 8'b0010_0000;
    set_word(5, 16'hBEEF);
    step("bp_fill");
    in_valid = 8'b0100_0100;
    set_word(2, 16'h2222);
    set_word(6, 16'h6666);
    for (int i = 0; i < 4; i++) step("bp_stall");
    n_checks++;
    if (out_data !== 16'hBEEF || out_sel !== 3'd5) begin
      n_fail++;
      $display("FAIL bp_hold: got d=%h s=%0d expected d=beef s=5", out_data, out_sel);
    end
    out_ready = 1'b1;
    step("bp_release");
    n_checks++;
    if (out_sel !== 3'd6) begin
      n_fail++;
      $display("FAIL bp_first: got s=%0d expected 6", out_sel);
    end
    in_valid[6] = 1'b0;
    step("bp_second");
    n_checks++;
    if (out_sel !== 3'd2) begin
      n_fail++;
      $display("FAIL bp_second_sel: got s=%0d expected 2", out_sel);
    end
    in_valid = 8'h00;
    step("bp_drain");
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 8'b0100_0000;
    set_word(6, 16'h0606);
    step("sparse_prime");
    in_valid = 8'b0000_0101;
    set_word(0, 16'hA000);
    set_word(2, 16'hA002);
    step("sparse_first");
    n_checks++;
    if (out_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL sparse_first_sel: got s=%0d expected 0", out_sel);
    end
    in_valid[0] = 1'b0;
    step("sparse_second");
    in_valid = 8'h00;
    n_checks++;
    if (out_sel !== 3'd2 || m_ptr != 3) begin
      n_fail++;
      $display("FAIL sparse_second_sel: got s=%0d ptr=%0d expected s=2 ptr=3", out_sel, m_ptr);
    end
    step("sparse_drain");
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 8'b0000_1000;
    set_word(3, 16'h3333);
    step("mid_fill");
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_async: got v=%b r=%b expected v=0 r=00000000", out_valid, in_ready);
    end
    model_reset();
    in_valid = 8'b0001_0001;
    set_word(0, 16'h0A0A);
    set_word(4, 16'h4B4B);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step("mid_after");
    n_checks++;
    if (out_sel !== 3'd0 || out_data !== 16'h0A0A) begin
      n_fail++;
      $display("FAIL mid_winner: got s=%0d d=%h expected s=0 d=0a0a", out_sel, out_data);
    end
    in_valid[0] = 1'b0;
    step("mid_next");
    in_valid = 8'h00;
    step("mid_drain");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step("random");
      for (int c = 0; c < 8; c++) begin
        if (!in_valid[c] || last_grant == c) begin
          in_valid[c] = ($urandom_range(0, 2) == 0);
          set_word(c, 16'($urandom));
        end
      end
    end
    in_valid  = 8'h00;
    out_ready = 1'b1;
    step("random_drain");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_sparse_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
